cva6_ptw_sv32: RTL and testbench
================================

Name: cva6_ptw_sv32

Overview:
- Sv32 hardware page-table walker that sits directly upstream of cva6_tlb_sv32.
- On a TLB miss reported by the MMU, it walks the two-level Sv32 page table through a single-outstanding memory port.
- A successful walk produces one 63-bit update_o word in exactly the format cva6_tlb_sv32.update_i consumes.
- Faulting walks raise walk_error_o and produce no update.

Parameters:
ASID_WIDTH, 1, width of ASID inputs; zero-extended to 9 bits in update_o.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  SFENCE/flush; aborts any walk in progress
satp_ppn_i  in  22  root page-table PPN
walk_req_i  in  1  walk request (TLB miss)
walk_vaddr_i  in  32  faulting virtual address
walk_asid_i  in  ASID_WIDTH  ASID of the request
walk_ready_o  out  1  high only in IDLE
mem_req_o  out  1  memory read request
mem_addr_o  out  34  physical PTE address
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  PTE
update_o  out  63  {valid, is_4M, vpn[19:0], asid[8:0], pte[31:0]}
walk_done_o  out  1  one-cycle pulse on successful walk
walk_error_o  out  1  one-cycle pulse on page fault
busy_o  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE. walk_ready_o rises one cycle after rst_ni deasserts.
- States: IDLE, WAIT_GNT, WAIT_RVALID, DONE, FAULT, DRAIN.
- IDLE: on walk_req_i, latch vaddr, asid and satp_ppn_i; set level=1; go to WAIT_GNT.
- WAIT_GNT: mem_req_o=1 with mem_addr_o held stable.
  - level 1: mem_addr_o = {satp_ppn, 12'b0} + vpn1*4.
  - level 0: mem_addr_o = {pte.ppn, 12'b0} + vpn0*4.
  - On mem_gnt_i, drop mem_req_o next cycle and go to WAIT_RVALID.
- WAIT_RVALID: on mem_rvalid_i, decode PTE (V=b0, R=b1, W=b2, X=b3, A=b6, PPN=b31:10).
  - Fault if V=0, or R=0&W=1, or the PTE is a leaf with A=0.
  - Leaf (R|X) at level 1 with PPN[9:0] != 0: fault (misaligned superpage).
  - Non-leaf at level 1: latch PPN, set level=0, go to WAIT_GNT.
  - Non-leaf at level 0: fault.
  - Valid leaf: go to DONE; is_4M = (level==1).
- DONE (one cycle): update_o = {1, is_4M, vaddr[31:12], zero-extended asid, pte}; walk_done_o=1. Next state IDLE; update_o[62] returns to 0.
- FAULT (one cycle): walk_error_o=1; update_o[62]=0; next state IDLE.
- update_o fields other than bit 62 hold their last value while bit 62 is 0.
- Walk latency with zero-wait memory (gnt same cycle, rvalid next cycle):
  - 4M leaf: DONE is 4 cycles after the request cycle.
  - 4K leaf: DONE is 6 cycles after the request cycle.
- flush_i handling:
  - In IDLE: ignored; walk_req_i is not accepted that cycle.
  - In WAIT_GNT with mem_gnt_i=0: go to IDLE immediately.
  - In WAIT_GNT with mem_gnt_i=1, or in WAIT_RVALID: go to DRAIN. DRAIN waits for mem_rvalid_i, discards the data, then goes to IDLE.
  - A flush never produces walk_done_o or walk_error_o.
  - flush_i in DONE or FAULT: the pulse still completes.
- Only one memory transaction is outstanding at any time. mem_rvalid_i outside WAIT_RVALID/DRAIN is ignored.
- Address arithmetic is 34-bit; no wrap checking.
- rst_ni assertion mid-walk returns to IDLE asynchronously. A late rvalid after reset is ignored.

Test Plan:
- 4K walk: satp_ppn=0x00080, vaddr=0x00401000, asid=1 -> L1 read at 0x00080004. Return 0x00024001 -> L0 read at 0x00090004. Return 0x048D14C7 -> update_o={1,0,0x00401,9'd1,0x048D14C7} plus walk_done_o for one cycle.
- 4M walk: vaddr=0x80000000, satp_ppn=0x00080 -> read at 0x00080800. Return 0x001000CF -> update_o is_4M=1, vpn=0x80000; no second read.
- Misaligned superpage: L1 returns 0x000004CF -> walk_error_o pulse; update_o[62] stays 0; walk_ready_o high the next cycle.
- Invalid PTEs: L1 returns 0x00000000 -> error. L0 returns non-leaf 0x00024001 -> error. Leaf with A=0 (0x048D1487) -> error.
- Flush mid-walk: flush_i during WAIT_RVALID -> DRAIN; rvalid data 0x048D14C7 is discarded; no done or error pulse; IDLE one cycle after rvalid.
- Grant stall: mem_gnt_i low for 5 cycles -> mem_req_o and mem_addr_o held stable; flush_i in the 3rd cycle -> mem_req_o drops and the block returns to IDLE with no drain.

Source files
------------

// File: rtl/cva6_ptw_sv32.sv
// Sv32 two-level hardware page-table walker feeding cva6_tlb_sv32.update_i.
// One memory read in flight at a time; completion and fault pulses are registered.
module cva6_ptw_sv32 #(
  parameter int unsigned ASID_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic                  walk_req_i,
  input  logic [31:0]           walk_vaddr_i,
  input  logic [ASID_WIDTH-1:0] walk_asid_i,
  output logic                  walk_ready_o,
  output logic                  mem_req_o,
  output logic [33:0]           mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [62:0]           update_o,
  output logic                  walk_done_o,
  output logic                  walk_error_o,
  output logic                  busy_o
);

  // Memory handshake: a read is offered while mem_req_o is high and counts as
  // accepted in the cycle mem_gnt_i is high; exactly one mem_rvalid_i answers it.
  typedef enum logic [2:0] {
    IDLE, WAIT_GNT, WAIT_RVALID, DONE, FAULT, DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic                  level_q, level_d;
  logic [19:0]           vpn_q, vpn_d;
  logic [ASID_WIDTH-1:0] asid_q, asid_d;
  logic [31:0]           pte_q, pte_d;
  logic [33:0]           addr_q, addr_d;
  logic [62:0]           upd_q, upd_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic        pte_v, pte_r, pte_w, pte_x, pte_a, pte_leaf;
  logic [21:0] pte_ppn;
  logic [8:0]  asid_ext;
  logic        unused_vaddr_bits;

  assign pte_v    = mem_rdata_i[0];
  assign pte_r    = mem_rdata_i[1];
  assign pte_w    = mem_rdata_i[2];
  assign pte_x    = mem_rdata_i[3];
  assign pte_a    = mem_rdata_i[6];
  assign pte_ppn  = mem_rdata_i[31:10];
  assign pte_leaf = pte_r | pte_x;
  assign asid_ext = 9'(asid_q);
  assign unused_vaddr_bits = ^walk_vaddr_i[11:0];

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    vpn_d   = vpn_q;
    asid_d  = asid_q;
    pte_d   = pte_q;
    addr_d  = addr_q;
    upd_d   = {1'b0, upd_q[61:0]};
    done_d  = 1'b0;
    error_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A flush in the same cycle as a request wins: the request is dropped.
        if (walk_req_i && ready_q && !flush_i) begin
          vpn_d   = walk_vaddr_i[31:12];
          asid_d  = walk_asid_i;
          level_d = 1'b1;
          addr_d  = {satp_ppn_i, 12'b0} + {22'b0, walk_vaddr_i[31:22], 2'b0};
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (flush_i) state_d = mem_gnt_i ? DRAIN : IDLE;
        else if (mem_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (mem_rvalid_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else if (!pte_v || (!pte_r && pte_w)) begin
            state_d = FAULT;
          end else if (pte_leaf) begin
            pte_d = mem_rdata_i;
            if (!pte_a || (level_q && (pte_ppn[9:0] != 10'd0))) state_d = FAULT;
            else state_d = DONE;
          end else if (level_q) begin
            level_d = 1'b0;
            addr_d  = {pte_ppn, 12'b0} + {22'b0, vpn_q[9:0], 2'b0};
            state_d = WAIT_GNT;
          end else begin
            state_d = FAULT;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        upd_d   = {1'b1, level_q, vpn_q, asid_ext, pte_q};
        state_d = IDLE;
      end
      FAULT: begin
        error_d = 1'b1;
        state_d = IDLE;
      end
      DRAIN: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Hold off new requests while the completion pulse of the last walk is visible.
    ready_d = (state_d == IDLE) && (state_q != DONE) && (state_q != FAULT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      level_q <= 1'b0;
      vpn_q   <= '0;
      asid_q  <= '0;
      pte_q   <= '0;
      addr_q  <= '0;
      upd_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      vpn_q   <= vpn_d;
      asid_q  <= asid_d;
      pte_q   <= pte_d;
      addr_q  <= addr_d;
      upd_q   <= upd_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign walk_ready_o = ready_q;
  assign mem_req_o    = (state_q == WAIT_GNT);
  assign mem_addr_o   = addr_q;
  assign update_o     = upd_q;
  assign walk_done_o  = done_q;
  assign walk_error_o = error_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_cva6_ptw_sv32.sv
// Directed bench for the Sv32 walker: hand-computed PTE addresses, update words,
// pulse timing, flush, grant stall and asynchronous reset cases.
module tb_cva6_ptw_sv32;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [21:0] satp_ppn;
  logic        walk_req;
  logic [31:0] walk_vaddr;
  logic [0:0]  walk_asid;
  logic        walk_ready;
  logic        mem_req;
  logic [33:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [62:0] update;
  logic        walk_done;
  logic        walk_error;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  cva6_ptw_sv32 #(.ASID_WIDTH(1)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .satp_ppn_i   (satp_ppn),
    .walk_req_i   (walk_req),
    .walk_vaddr_i (walk_vaddr),
    .walk_asid_i  (walk_asid),
    .walk_ready_o (walk_ready),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .update_o     (update),
    .walk_done_o  (walk_done),
    .walk_error_o (walk_error),
    .busy_o       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic issue(input logic [31:0] va, input logic [21:0] satp);
    check("ready_before_req", 64'(walk_ready), 64'd1);
    walk_req   = 1'b1;
    walk_vaddr = va;
    walk_asid  = 1'b1;
    satp_ppn   = satp;
    tick();
    walk_req   = 1'b0;
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
  endtask

  // Fault sequence tail: FAULT state now, pulse next cycle, ready the cycle after.
  task automatic expect_fault(input string tag, input logic [61:0] held);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_err_early"}, 64'(walk_error), 64'd0);
    tick();
    check({tag, "_err"}, 64'(walk_error), 64'd1);
    check({tag, "_done"}, 64'(walk_done), 64'd0);
    check({tag, "_upd"}, 64'(update), 64'({1'b0, held}));
    check({tag, "_ready_low"}, 64'(walk_ready), 64'd0);
    tick();
    check({tag, "_err_clr"}, 64'(walk_error), 64'd0);
    check({tag, "_ready"}, 64'(walk_ready), 64'd1);
  endtask

  logic [62:0] exp_4k, exp_4m;

  initial begin
    exp_4k = {1'b1, 1'b0, 20'h00401, 9'd1, 32'h048D14C7};
    exp_4m = {1'b1, 1'b1, 20'h80000, 9'd1, 32'h001000CF};

    rst_n = 1'b0; flush = 1'b0; satp_ppn = '0; walk_req = 1'b0; walk_vaddr = '0;
    walk_asid = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst_ready", 64'(walk_ready), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_update", 64'(update), 64'd0);
    check("rst_pulses", 64'({walk_done, walk_error, busy}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_at_release", 64'(walk_ready), 64'd0);
    tick();
    check("ready_after_release", 64'(walk_ready), 64'd1);

    // 4K walk
    issue(32'h00401000, 22'h00080);
    check("4k_l1_req", 64'(mem_req), 64'd1);
    check("4k_l1_addr", 64'(mem_addr), 64'h00080004);
    check("4k_ready_busy", 64'({walk_ready, busy}), 64'b01);
    grant();
    check("4k_l1_req_drop", 64'(mem_req), 64'd0);
    respond(32'h00024001);
    check("4k_l0_req", 64'(mem_req), 64'd1);
    check("4k_l0_addr", 64'(mem_addr), 64'h00090004);
    grant();
    respond(32'h048D14C7);
    check("4k_done_early", 64'(walk_done), 64'd0);
    tick();
    check("4k_done", 64'(walk_done), 64'd1);
    check("4k_update", 64'(update), 64'(exp_4k));
    check("4k_err", 64'(walk_error), 64'd0);
    tick();
    check("4k_done_clr", 64'(walk_done), 64'd0);
    check("4k_valid_clr", 64'(update), 64'({1'b0, exp_4k[61:0]}));
    check("4k_ready", 64'(walk_ready), 64'd1);

    // 4M walk, flush during DONE must not suppress the pulse
    issue(32'h80000000, 22'h00080);
    check("4m_addr", 64'(mem_addr), 64'h00080800);
    grant();
    respond(32'h001000CF);
    check("4m_no_second_read", 64'(mem_req), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("4m_done", 64'(walk_done), 64'd1);
    check("4m_update", 64'(update), 64'(exp_4m));
    check("4m_no_read_after", 64'(mem_req), 64'd0);
    tick();
    check("4m_done_clr", 64'(walk_done), 64'd0);

    // misaligned superpage
    issue(32'h80000000, 22'h00080);
    grant();
    respond(32'h000004CF);
    expect_fault("misaligned", exp_4m[61:0]);

    // invalid L1
    issue(32'h00401000, 22'h00080);
    grant();
    respond(32'h00000000);
    expect_fault("l1_invalid", exp_4m[61:0]);

    // non-leaf at L0
    issue(32'h00401000, 22'h00080);
    grant();
    respond(32'h00024001);
    grant();
    respond(32'h00024001);
    expect_fault("l0_nonleaf", exp_4m[61:0]);

    // leaf with A=0 at L0
    issue(32'h00401000, 22'h00080);
    grant();
    respond(32'h00024001);
    grant();
    respond(32'h048D1487);
    expect_fault("l0_a_clear", exp_4m[61:0]);

    // flush during WAIT_RVALID drains the outstanding read
    issue(32'h00401000, 22'h00080);
    grant();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drain_busy", 64'(busy), 64'd1);
    check("drain_req", 64'(mem_req), 64'd0);
    respond(32'h048D14C7);
    check("drain_idle", 64'(busy), 64'd0);
    check("drain_ready", 64'(walk_ready), 64'd1);
    check("drain_pulses", 64'({walk_done, walk_error}), 64'd0);
    tick();
    check("drain_pulses_late", 64'({walk_done, walk_error}), 64'd0);
    check("drain_update", 64'(update), 64'({1'b0, exp_4m[61:0]}));

    // grant stall then flush: no drain
    issue(32'h00401000, 22'h00080);
    for (int i = 0; i < 3; i++) begin
      check("stall_req", 64'(mem_req), 64'd1);
      check("stall_addr", 64'(mem_addr), 64'h00080004);
      if (i == 2) flush = 1'b1;
      tick();
    end
    flush = 1'b0;
    check("stall_flush_req", 64'(mem_req), 64'd0);
    check("stall_flush_idle", 64'(busy), 64'd0);
    check("stall_flush_ready", 64'(walk_ready), 64'd1);
    tick();
    check("stall_pulses", 64'({walk_done, walk_error}), 64'd0);

    // flush in IDLE blocks the request that cycle
    walk_req = 1'b1; flush = 1'b1;
    tick();
    walk_req = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 64'(busy), 64'd0);
    check("idle_flush_req", 64'(mem_req), 64'd0);

    // asynchronous reset mid-walk; the late rvalid is ignored
    issue(32'h80000000, 22'h00080);
    grant();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ready", 64'(walk_ready), 64'd0);
    check("arst_update", 64'(update), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_ready_back", 64'(walk_ready), 64'd1);
    respond(32'h001000CF);
    check("late_rvalid_busy", 64'(busy), 64'd0);
    tick();
    check("late_rvalid_pulses", 64'({walk_done, walk_error}), 64'd0);
    check("late_rvalid_update", 64'(update), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
